// File: rtl/cdc_level_qualifier.sv
// -----------------------------------------------------------------------------
// cdc_level_qualifier
//
// Purpose:
//   Sits after a 2-flop synchronizer in the destination clock domain. It does
//   not synchronize anything itself. A change on sync_in is accepted only after
//   STABLE_CYCLES consecutive identical samples. Shorter excursions are counted
//   as glitches and dropped. Every accepted change produces a single-cycle rise
//   or fall strobe. Two debug counters track qualified rises (wrapping) and
//   aborted qualifications (saturating).
//
// Parameters:
//   STABLE_CYCLES  consecutive identical samples needed to accept a change (>=1)
//   CNT_W          qualification counter width; 2**CNT_W must exceed STABLE_CYCLES
//   EVT_W          width of rise_count / glitch_count
//
// Ports:
//   clk_dest      in   destination clock; all logic runs on its rising edge
//   rst_n         in   synchronous active-low reset
//   sync_in       in   already-synchronized level (the synchronizer's sync_out)
//   clr_counts    in   synchronous clear of both counters; wins over increment
//   level_out     out  qualified level
//   rise_pulse    out  one-cycle strobe when level_out goes 0->1
//   fall_pulse    out  one-cycle strobe when level_out goes 1->0
//   rise_count    out  qualified rises, wraps
//   glitch_count  out  aborted qualifications, saturates at all-ones
//   state_dbg     out  current FSM state, for checkers and debug
//
// Interface timing: there is no handshake. Every output is a registered level.
// rise_pulse and fall_pulse are strobes, and each is meaningful only in the
// cycle in which it is high. A consumer must sample them every cycle.
// -----------------------------------------------------------------------------
module cdc_level_qualifier #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 4,
   parameter int EVT_W         = 8
) (
   input  logic             clk_dest,
   input  logic             rst_n,
   input  logic             sync_in,
   input  logic             clr_counts,
   output logic             level_out,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [EVT_W-1:0] rise_count,
   output logic [EVT_W-1:0] glitch_count,
   output logic [1:0]       state_dbg
);

   // The encoding is {qualified level, qualification in progress}. A debug
   // reader can therefore decode state_dbg without a lookup table.
   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      QUAL_HI   = 2'b01,
      STABLE_HI = 2'b10,
      QUAL_LO   = 2'b11
   } state_t;

   // Counter value seen on the edge before the final confirming sample.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               rise_evt;
   logic               fall_evt;
   logic               glitch_evt;

   // Next-state and event decode.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      rise_evt   = 1'b0;
      fall_evt   = 1'b0;
      glitch_evt = 1'b0;

      case (state)
         STABLE_LO: begin
            if (sync_in) begin
               // With STABLE_CYCLES=1 the first differing sample is enough.
               if (STABLE_CYCLES == 1) begin
                  state_nxt = STABLE_HI;
                  cnt_nxt   = '0;
                  rise_evt  = 1'b1;
               end else begin
                  state_nxt = QUAL_HI;
                  cnt_nxt   = CNT_W'(1);
               end
            end
         end

         QUAL_HI: begin
            if (!sync_in) begin
               state_nxt  = STABLE_LO;
               cnt_nxt    = '0;
               glitch_evt = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nxt = STABLE_HI;
               cnt_nxt   = '0;
               rise_evt  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         STABLE_HI: begin
            if (!sync_in) begin
               if (STABLE_CYCLES == 1) begin
                  state_nxt = STABLE_LO;
                  cnt_nxt   = '0;
                  fall_evt  = 1'b1;
               end else begin
                  state_nxt = QUAL_LO;
                  cnt_nxt   = CNT_W'(1);
               end
            end
         end

         QUAL_LO: begin
            if (sync_in) begin
               state_nxt  = STABLE_HI;
               cnt_nxt    = '0;
               glitch_evt = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nxt = STABLE_LO;
               cnt_nxt   = '0;
               fall_evt  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State register and registered outputs.
   always_ff @(posedge clk_dest) begin
      if (!rst_n) begin
         state        <= STABLE_LO;
         cnt          <= '0;
         level_out    <= 1'b0;
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
         rise_count   <= '0;
         glitch_count <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         rise_pulse <= rise_evt;
         fall_pulse <= fall_evt;

         // level_out moves only on a completed event. It holds its value
         // throughout qualification.
         if (rise_evt) begin
            level_out <= 1'b1;
         end else if (fall_evt) begin
            level_out <= 1'b0;
         end

         if (clr_counts) begin
            rise_count <= '0;
         end else if (rise_evt) begin
            rise_count <= rise_count + 1'b1;
         end

         if (clr_counts) begin
            glitch_count <= '0;
         end else if (glitch_evt && (glitch_count != '1)) begin
            glitch_count <= glitch_count + 1'b1;
         end
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_cdc_level_qualifier.sv
// -----------------------------------------------------------------------------
// tb_cdc_level_qualifier
//
// Purpose:
//   Self-checking bench for cdc_level_qualifier with STABLE_CYCLES=4, EVT_W=4
//   and a 10 ns clock.
//
// Reference model:
//   The model tracks the accepted level and the length of the current run of
//   samples that disagree with it. When that run reaches STABLE_CYCLES, the
//   level flips and an event fires. A run that ends early is a glitch.
//
// Structure:
//   - The driver applies one input vector per cycle and pushes the expected
//     post-edge outputs.
//   - The monitor pops one entry after each rising edge and compares it with
//     the DUT outputs.
//   - Directed checks at scenario boundaries compare against fixed values.
// -----------------------------------------------------------------------------
module tb_cdc_level_qualifier;

   localparam int N  = 4;
   localparam int CW = 4;
   localparam int EW = 4;
   localparam int W  = 5 + 2 * EW;

   // Clock and DUT signals.
   logic          clk_dest = 1'b0;
   logic          rst_n;
   logic          sync_in;
   logic          clr_counts;
   logic          level_out;
   logic          rise_pulse;
   logic          fall_pulse;
   logic [EW-1:0] rise_count;
   logic [EW-1:0] glitch_count;
   logic [1:0]    state_dbg;

   always #5 clk_dest = ~clk_dest;

   cdc_level_qualifier #(
      .STABLE_CYCLES (N),
      .CNT_W         (CW),
      .EVT_W         (EW)
   ) dut (
      .clk_dest     (clk_dest),
      .rst_n        (rst_n),
      .sync_in      (sync_in),
      .clr_counts   (clr_counts),
      .level_out    (level_out),
      .rise_pulse   (rise_pulse),
      .fall_pulse   (fall_pulse),
      .rise_count   (rise_count),
      .glitch_count (glitch_count),
      .state_dbg    (state_dbg)
   );

   // Scoreboard state.
   logic [W-1:0] exp_q[$];
   int           vectors     = 0;
   int           miscompares = 0;

   // Reference model state.
   logic m_level = 1'b0;
   int   m_run   = 0;
   int   m_rc    = 0;
   int   m_gc    = 0;
   logic m_rise  = 1'b0;
   logic m_fall  = 1'b0;

   function automatic logic [W-1:0] pack(input logic lvl, input logic rp,
                                         input logic fp, input logic [1:0] st,
                                         input logic [EW-1:0] rc,
                                         input logic [EW-1:0] gc);
      return {lvl, rp, fp, st, rc, gc};
   endfunction

   // Advance the model by one edge and update its outputs.
   task automatic model_step(input logic s, input logic c, input logic r);
      logic glitch;
      glitch = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (!r) begin
         m_level = 1'b0;
         m_run   = 0;
         m_rc    = 0;
         m_gc    = 0;
      end else begin
         if (s != m_level) begin
            m_run = m_run + 1;
            if (m_run == N) begin
               m_level = s;
               m_rise  = s;
               m_fall  = ~s;
               m_run   = 0;
            end
         end else begin
            if (m_run > 0) glitch = 1'b1;
            m_run = 0;
         end
         if (c) m_rc = 0;
         else if (m_rise) m_rc = (m_rc + 1) % (1 << EW);
         if (c) m_gc = 0;
         else if (glitch && m_gc != (1 << EW) - 1) m_gc = m_gc + 1;
      end
   endtask

   // Driver: apply inputs, push the expectation, and return at the following
   // falling edge, when the DUT outputs reflect those inputs.
   task automatic drive(input logic s, input logic c, input logic r);
      sync_in    = s;
      clr_counts = c;
      rst_n      = r;
      model_step(s, c, r);
      exp_q.push_back(pack(m_level, m_rise, m_fall, {m_level, (m_run != 0)},
                           EW'(m_rc), EW'(m_gc)));
      @(negedge clk_dest);
   endtask

   task automatic check(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
      end
   endtask

   // Monitor: compare once per cycle, shortly after the active edge.
   logic [W-1:0] mon_exp;
   logic [W-1:0] mon_act;
   always @(posedge clk_dest) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_act = pack(level_out, rise_pulse, fall_pulse, state_dbg,
                        rise_count, glitch_count);
         vectors++;
         if (mon_act !== mon_exp) begin
            miscompares++;
            $display("FAIL cycle_check at %0t: got {lvl,rp,fp,st,rc,gc}=%h, expected %h",
                     $time, mon_act, mon_exp);
         end
      end
   end

   // Watchdog.
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic v;
      int   len;
      sync_in    = 1'b0;
      clr_counts = 1'b0;
      rst_n      = 1'b0;
      @(negedge clk_dest);

      // 1. Reset with sync_in high, then qualify the rise.
      repeat (2) drive(1'b1, 1'b0, 1'b0);
      check("reset_level", level_out, 0);
      check("reset_rise_pulse", rise_pulse, 0);
      check("reset_rise_count", rise_count, 0);
      check("reset_glitch_count", glitch_count, 0);
      check("reset_state", state_dbg, 0);
      repeat (3) drive(1'b1, 1'b0, 1'b1);
      check("level_held_during_qual", level_out, 0);
      drive(1'b1, 1'b0, 1'b1);
      check("rise_level", level_out, 1);
      check("rise_pulse", rise_pulse, 1);
      check("rise_count_first", rise_count, 1);
      drive(1'b1, 1'b0, 1'b1);
      check("rise_pulse_one_cycle", rise_pulse, 0);
      repeat (3) drive(1'b0, 1'b0, 1'b1);
      check("level_held_during_fall_qual", level_out, 1);
      drive(1'b0, 1'b0, 1'b1);
      check("fall_pulse", fall_pulse, 1);
      check("fall_level", level_out, 0);
      repeat (2) drive(1'b0, 1'b0, 1'b1);

      // 2. Glitches until glitch_count saturates.
      drive(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, 1'b1);
         drive(1'b1, 1'b0, 1'b1);
         drive(1'b0, 1'b0, 1'b1);
         if (i == 0) check("glitch_count_first", glitch_count, 1);
         drive(1'b0, 1'b0, 1'b1);
      end
      check("glitch_count_saturated", glitch_count, 15);
      check("glitch_level_stays_low", level_out, 0);
      check("glitch_rise_count", rise_count, 0);

      // 3. One full high/low cycle after a clear.
      drive(1'b0, 1'b1, 1'b1);
      repeat (6) drive(1'b1, 1'b0, 1'b1);
      repeat (6) drive(1'b0, 1'b0, 1'b1);
      check("full_cycle_rise_count", rise_count, 1);
      check("full_cycle_glitch_count", glitch_count, 0);
      check("full_cycle_level", level_out, 0);

      // 4. rise_count wrap.
      drive(1'b0, 1'b1, 1'b1);
      for (int i = 1; i <= 17; i++) begin
         repeat (5) drive(1'b1, 1'b0, 1'b1);
         if (i == 15) check("wrap_count_15", rise_count, 15);
         if (i == 16) check("wrap_count_16", rise_count, 0);
         if (i == 17) check("wrap_count_17", rise_count, 1);
         repeat (5) drive(1'b0, 1'b0, 1'b1);
      end

      // 5. Clear coinciding with a qualifying rise.
      drive(1'b0, 1'b1, 1'b1);
      repeat (5) begin
         repeat (5) drive(1'b1, 1'b0, 1'b1);
         repeat (5) drive(1'b0, 1'b0, 1'b1);
      end
      check("pre_clear_rise_count", rise_count, 5);
      repeat (3) drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b1);
      check("clear_wins_rise_count", rise_count, 0);
      check("clear_keeps_rise_pulse", rise_pulse, 1);
      check("clear_keeps_level", level_out, 1);

      // 6. Reset during QUAL_LO with cnt=2.
      repeat (2) drive(1'b1, 1'b0, 1'b1);
      repeat (2) drive(1'b0, 1'b0, 1'b1);
      check("qual_lo_state", state_dbg, 3);
      drive(1'b0, 1'b0, 1'b0);
      check("midrst_level", level_out, 0);
      check("midrst_no_fall_pulse", fall_pulse, 0);
      check("midrst_rise_count", rise_count, 0);
      check("midrst_state", state_dbg, 0);

      // Randomized runs of varying length, with occasional clears and resets.
      v = 1'b0;
      for (int i = 0; i < 400; i++) begin
         v   = ~v;
         len = $urandom_range(1, 7);
         for (int k = 0; k < len; k++) begin
            drive(v, ($urandom_range(0, 19) == 0), ($urandom_range(0, 149) != 0));
         end
      end
      rst_n      = 1'b1;
      clr_counts = 1'b0;

      // Drain the scoreboard.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_dest);
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
